// File: rtl/hv_pkg.sv
// Shared constants and types for the HV supply reply parser.
// Holds the frame delimiters, the error-code encoding and the parser state type.
package hv_pkg;

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;
    localparam logic [7:0] CR  = 8'h0D;

    typedef enum logic [1:0] {
        ERR_CHECKSUM = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_FRAMING  = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHK     = 2'd2,
        ST_EOL     = 2'd3
    } state_e;

endpackage

// File: rtl/hv_pp_buffer.sv
// Ping-pong payload store: the parser fills the write bank while the reader sees
// the last committed frame; a swap pulse exchanges the two banks.
module hv_pp_buffer
    import hv_pkg::*;
#(
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          swap_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [7:0] mem_q [2][DEPTH];
    logic       rd_bank_q, rd_bank_d;
    logic [7:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_bank_d = rd_bank_q ^ swap_i;
        rd_data_d = mem_q[rd_bank_q][rd_addr_i];
    end

    // Storage is deliberately not reset; only the bank pointer and read register are.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[~rd_bank_q][wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_bank_q <= 1'b0;
            rd_data_q <= '0;
        end else if (clr_i) begin
            rd_bank_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_bank_q <= rd_bank_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hv_reply_parser.sv
// Parses STX/payload/ETX/XOR-checksum/CR reply frames from a UART byte stream,
// committing good payloads to a ping-pong buffer and flagging dropped frames.
module hv_reply_parser
    import hv_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       frame_valid,
    output logic [4:0] frame_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [4:0]  MAX_CNT  = 5'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic [7:0]    xor_q, xor_d;
    logic          mism_q, mism_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fv_q, fv_d;
    logic          fe_q, fe_d;
    err_code_e     ec_q, ec_d;
    logic [4:0]    len_q, len_d;
    logic          wr_en, commit, expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            xor_q   <= '0;
            mism_q  <= 1'b0;
            tmo_q   <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ec_q    <= ERR_CHECKSUM;
            len_q   <= '0;
        end else if (soft_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            xor_q   <= '0;
            mism_q  <= 1'b0;
            tmo_q   <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ec_q    <= ERR_CHECKSUM;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            xor_q   <= xor_d;
            mism_q  <= mism_d;
            tmo_q   <= tmo_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            ec_q    <= ec_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        xor_d   = xor_q;
        mism_d  = mism_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        ec_d    = ec_q;
        len_d   = len_q;
        expire  = (state_q != ST_IDLE) && !din_valid && (tmo_q == TMO_LAST);

        if (state_q == ST_IDLE || din_valid) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // A byte on the expiry cycle keeps the frame alive: expire requires !din_valid.
        if (expire) begin
            state_d = ST_IDLE;
            fe_d    = 1'b1;
            ec_d    = ERR_TIMEOUT;
            tmo_d   = '0;
        end else if (din_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (din == STX) begin
                        state_d = ST_PAYLOAD;
                        count_d = '0;
                        xor_d   = '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (din == ETX) begin
                        state_d = ST_CHK;
                    end else if (count_q == MAX_CNT) begin
                        state_d = ST_IDLE;
                        fe_d    = 1'b1;
                        ec_d    = ERR_OVERFLOW;
                    end else if (din == STX) begin
                        count_d = '0;
                        xor_d   = '0;
                    end else begin
                        count_d = count_q + 5'd1;
                        xor_d   = xor_q ^ din;
                    end
                end
                ST_CHK: begin
                    mism_d  = (din != xor_q);
                    state_d = ST_EOL;
                end
                ST_EOL: begin
                    state_d = ST_IDLE;
                    if (commit) begin
                        fv_d  = 1'b1;
                        len_d = count_q;
                    end else begin
                        fe_d = 1'b1;
                        ec_d = (din == CR) ? ERR_CHECKSUM : ERR_FRAMING;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        wr_en  = din_valid && (state_q == ST_PAYLOAD) && (din != ETX) &&
                 (din != STX) && (count_q != MAX_CNT);
        commit = din_valid && (state_q == ST_EOL) && (din == CR) && !mism_q;
    end

    hv_pp_buffer #(
        .AW (AW)
    ) u_buf (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (soft_rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (count_q[AW-1:0]),
        .wr_data_i (din),
        .swap_i    (commit),
        .rd_addr_i (rd_addr[AW-1:0]),
        .rd_data_o (rd_data)
    );

    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign err_code    = ec_q;
    assign frame_len   = len_q;

endmodule

// File: tb/tb_hv_reply_parser.sv
// Directed bench for hv_reply_parser: expected frame events are queued as bytes
// are sent and matched against frame_valid/frame_err pulses as they appear.
module tb_hv_reply_parser;

    localparam int unsigned TMO = 40000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       soft_rst = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [4:0] len;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    hv_reply_parser #(
        .MAX_LEN     (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst    (soft_rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input bit is_err, input logic [1:0] code, input logic [4:0] len);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.len    = len;
        sbq.push_back(e);
    endtask

    task automatic handle();
        exp_t e;
        if (sbq.size() == 0) begin
            check("spurious_event", {30'd0, frame_valid, frame_err}, 32'd0);
            return;
        end
        e = sbq.pop_front();
        check("ev_valid", {31'd0, frame_valid}, {31'd0, !e.is_err});
        check("ev_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("ev_len", {27'd0, frame_len}, {27'd0, e.len});
        if (e.is_err) check("ev_code", {30'd0, err_code}, {30'd0, e.code});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_valid || frame_err) handle();
    endtask

    task automatic send_byte(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            tick();
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) tick();
        check(tag, sbq.size(), 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        check(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] fr[$];
        int n;

        repeat (3) tick();
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_code", {30'd0, err_code}, 32'd0);
        check("rst_len", {27'd0, frame_len}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", {24'd0, rd_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // good two-byte frame
        expect_ev(1'b0, 2'd0, 5'd2);
        send_byte(8'h02);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        tick();
        fr = '{8'hA5, 8'h5A, 8'h03, 8'hFF, 8'h0D};
        send_frame(fr);
        drain("good_drain");
        read_chk("good_rd0", 4'd0, 8'hA5);
        read_chk("good_rd1", 4'd1, 8'h5A);

        // checksum error leaves the committed frame alone
        expect_ev(1'b1, 2'd0, 5'd2);
        fr = '{8'h02, 8'hA5, 8'h5A, 8'h03, 8'h00, 8'h0D};
        send_frame(fr);
        drain("chk_drain");
        read_chk("chk_rd0_kept", 4'd0, 8'hA5);
        read_chk("chk_rd1_kept", 4'd1, 8'h5A);

        // overflow on the 17th payload byte
        expect_ev(1'b1, 2'd1, 5'd2);
        send_byte(8'h02);
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h11);
            if (i == 15) check("ovf_not_early", sbq.size(), 32'd1);
        end
        check("ovf_at_17", sbq.size(), 32'd0);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        drain("ovf_drain");

        // framing error, then an empty good frame
        expect_ev(1'b1, 2'd2, 5'd2);
        fr = '{8'h02, 8'hA5, 8'h03, 8'hA5, 8'h0A};
        send_frame(fr);
        drain("frm_drain");
        expect_ev(1'b0, 2'd0, 5'd0);
        fr = '{8'h02, 8'h03, 8'h00, 8'h0D};
        send_frame(fr);
        drain("empty_drain");
        check("code_held", {30'd0, err_code}, 32'd2);

        // inter-byte timeout
        expect_ev(1'b1, 2'd3, 5'd0);
        send_byte(8'h02);
        send_byte(8'hA5);
        n = 0;
        while (sbq.size() != 0 && n < TMO + 100) begin
            tick();
            n++;
        end
        check("tmo_latency", n, TMO);
        check("tmo_busy", {31'd0, busy}, 32'd0);

        // a byte landing on the expiry cycle keeps the frame alive
        expect_ev(1'b0, 2'd0, 5'd2);
        send_byte(8'h02);
        send_byte(8'hA5);
        repeat (TMO - 1) tick();
        check("edge_no_tmo", sbq.size(), 32'd1);
        send_byte(8'h5A);
        check("edge_busy", {31'd0, busy}, 32'd1);
        fr = '{8'h03, 8'hFF, 8'h0D};
        send_frame(fr);
        drain("edge_drain");
        read_chk("edge_rd1", 4'd1, 8'h5A);

        // STX inside payload restarts the frame
        expect_ev(1'b0, 2'd0, 5'd1);
        fr = '{8'h02, 8'h11, 8'h02, 8'h22, 8'h03, 8'h22, 8'h0D};
        send_frame(fr);
        drain("restart_drain");
        read_chk("restart_rd0", 4'd0, 8'h22);

        // soft reset mid-frame
        send_byte(8'h02);
        send_byte(8'h33);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        check("srst_busy", {31'd0, busy}, 32'd0);
        check("srst_len", {27'd0, frame_len}, 32'd0);
        check("srst_rdata", {24'd0, rd_data}, 32'd0);
        check("srst_code", {30'd0, err_code}, 32'd0);
        drain("srst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
